cmd_parser: RTL

Upstream command-frame decoder for the register block. It receives a host byte stream from the serial receiver and validates each frame's address, length and XOR checksum. Valid payloads are buffered and replayed one byte per cycle as `master_data` plus a one-hot `valid_bus` strobe. It sits between the byte receiver and the register block, and is the only source of `master_data`/`valid_bus` for it.

---
 rtl/cmd_parser_if.sv | 37 +++
 rtl/cmd_parser.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cmd_parser_if.sv
// cmd_parser_if
// Purpose: bundles the byte-receiver handshake and the register-block
//          write port of cmd_parser into one interface.
// Signals:
//   rx_data     [7:0]   received byte
//   rx_valid            one-cycle strobe, rx_data valid
//   rx_ready            parser can accept a byte this cycle
//   master_data [7:0]   payload byte to the register block
//   valid_bus   [N-1:0] one-hot write strobe, bit = frame address
//   frame_err           one-cycle pulse on frame abort
//   err_code    [1:0]   abort cause, held until the next abort
//   overrun             one-cycle pulse when a byte arrives while not ready
// Modports:
//   master - byte source / register-block side (drives rx_*, observes outputs)
//   slave  - the parser itself
interface cmd_parser_if #(
    parameter int N = 26
);
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [7:0]   master_data;
    logic [N-1:0] valid_bus;
    logic         frame_err;
    logic [1:0]   err_code;
    logic         overrun;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, master_data, valid_bus, frame_err, err_code, overrun
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, master_data, valid_bus, frame_err, err_code, overrun
    );
endinterface

// File: rtl/cmd_parser.sv
// cmd_parser
// Purpose: decodes host command frames (SYNC 0xAA, ADDR, LEN, payload, CHK),
//          checks address range, length and XOR checksum, buffers the payload
//          and replays it one byte per cycle with a one-hot address strobe.
// Ports:
//   clk    - system clock
//   n_rst  - asynchronous active-low reset
//   bus    - cmd_parser_if.slave (byte input handshake + register-block outputs)
// Parameters:
//   N       - number of register addresses (width of valid_bus)
//   MAX_LEN - maximum payload length / buffer depth
//   TIMEOUT - idle clk cycles tolerated between bytes inside a frame
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | hunting for SYNC, other bytes silently dropped
// ADDR   | waiting for address byte
// LEN    | waiting for length byte
// DATA   | collecting payload bytes into the buffer
// CHK    | waiting for checksum byte
// PLAY   | replaying buffer to register block, rx_ready low
module cmd_parser #(
    parameter int N       = 26,
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 50000
) (
    input  logic         clk,
    input  logic         n_rst,
    cmd_parser_if.slave  bus
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [7:0]    SYNC     = 8'hAA;
    localparam logic [7:0]    N_B      = 8'(N);
    localparam logic [7:0]    MAX_B    = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] E_ADDR = 2'd0;
    localparam logic [1:0] E_LEN  = 2'd1;
    localparam logic [1:0] E_CHK  = 2'd2;
    localparam logic [1:0] E_TMO  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CHK,
        S_PLAY
    } state_t;

    state_t         r_state;
    logic           r_rx_ready;
    logic [7:0]     r_master_data;
    logic [N-1:0]   r_valid_bus;
    logic           r_frame_err;
    logic [1:0]     r_err_code;
    logic           r_overrun;

    logic [7:0]     r_addr;
    logic [7:0]     r_xor;
    logic [LW-1:0]  r_len;
    logic [LW-1:0]  r_cnt;
    logic [LW-1:0]  r_rd;
    logic [TW-1:0]  r_tmo;
    logic [7:0]     r_buf [MAX_LEN];

    logic           w_accept;
    logic           w_in_frame;
    logic           w_tmo_hit;
    logic [N-1:0]   w_onehot;
    logic [LW-1:0]  w_cnt_inc;
    logic [LW-1:0]  w_rd_inc;

    assign w_accept   = bus.rx_valid & r_rx_ready;
    assign w_in_frame = (r_state == S_ADDR) || (r_state == S_LEN) ||
                        (r_state == S_DATA) || (r_state == S_CHK);
    // The counter is compared before it increments, so the abort edge is the
    // one where the count would reach TIMEOUT; a byte in that cycle wins.
    assign w_tmo_hit  = w_in_frame && !w_accept && (r_tmo == TMO_LAST);
    assign w_onehot   = {{(N-1){1'b0}}, 1'b1} << r_addr;
    assign w_cnt_inc  = r_cnt + LW'(1);
    assign w_rd_inc   = r_rd + LW'(1);

    assign bus.rx_ready    = r_rx_ready;
    assign bus.master_data = r_master_data;
    assign bus.valid_bus   = r_valid_bus;
    assign bus.frame_err   = r_frame_err;
    assign bus.err_code    = r_err_code;
    assign bus.overrun     = r_overrun;

    // Payload storage has no reset: contents are only read after being written.
    always_ff @(posedge clk) begin
        if (r_state == S_DATA && w_accept) begin
            r_buf[r_cnt[IW-1:0]] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state       <= S_IDLE;
            r_rx_ready    <= 1'b1;
            r_master_data <= '0;
            r_valid_bus   <= '0;
            r_frame_err   <= 1'b0;
            r_err_code    <= '0;
            r_overrun     <= 1'b0;
            r_addr        <= '0;
            r_xor         <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_rd          <= '0;
            r_tmo         <= '0;
        end else begin
            r_frame_err   <= 1'b0;
            r_overrun     <= bus.rx_valid & ~r_rx_ready;
            r_valid_bus   <= '0;
            r_master_data <= '0;

            if (w_accept || !w_in_frame) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept && bus.rx_data == SYNC) begin
                        r_state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (w_accept) begin
                        r_addr <= bus.rx_data;
                        r_xor  <= bus.rx_data;
                        if (bus.rx_data >= N_B) begin
                            r_state     <= S_IDLE;
                            r_frame_err <= 1'b1;
                            r_err_code  <= E_ADDR;
                        end else begin
                            r_state <= S_LEN;
                        end
                    end
                end
                S_LEN: begin
                    if (w_accept) begin
                        if (bus.rx_data == 8'd0 || bus.rx_data > MAX_B) begin
                            r_state     <= S_IDLE;
                            r_frame_err <= 1'b1;
                            r_err_code  <= E_LEN;
                        end else begin
                            r_len   <= bus.rx_data[LW-1:0];
                            r_cnt   <= '0;
                            r_xor   <= r_xor ^ bus.rx_data;
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_cnt <= w_cnt_inc;
                        r_xor <= r_xor ^ bus.rx_data;
                        if (w_cnt_inc == r_len) begin
                            r_state <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (w_accept) begin
                        if (bus.rx_data != r_xor) begin
                            r_state     <= S_IDLE;
                            r_frame_err <= 1'b1;
                            r_err_code  <= E_CHK;
                        end else begin
                            // First byte goes out on the very next cycle, so it
                            // is issued here and replay continues from index 1.
                            r_state       <= S_PLAY;
                            r_rx_ready    <= 1'b0;
                            r_valid_bus   <= w_onehot;
                            r_master_data <= r_buf[0];
                            r_rd          <= LW'(1);
                        end
                    end
                end
                S_PLAY: begin
                    if (r_rd == r_len) begin
                        r_state    <= S_IDLE;
                        r_rx_ready <= 1'b1;
                    end else begin
                        r_valid_bus   <= w_onehot;
                        r_master_data <= r_buf[r_rd[IW-1:0]];
                        r_rd          <= w_rd_inc;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_rx_ready <= 1'b1;
                end
            endcase

            if (w_tmo_hit) begin
                r_state     <= S_IDLE;
                r_frame_err <= 1'b1;
                r_err_code  <= E_TMO;
            end
        end
    end

endmodule
